// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU trace/halt monitor: trace kinds, halt-cause
// bit positions, FSM states and a saturating counter helper.
package cpu_trace_buffer_pkg;

  localparam logic TRACE_REG = 1'b0;
  localparam logic TRACE_MEM = 1'b1;

  localparam int unsigned HALT_LIMIT_BIT = 0;
  localparam int unsigned HALT_WP_BIT    = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == '1) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_fifo.sv
// Dual-push / single-pop circular buffer. Push port 0 has priority for the
// last free slot; free space is evaluated before any same-cycle pop.
module cpu_trace_buffer_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      fill,
  output logic             drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [AW:0]      free;
  logic [AW-1:0]    wr1_ptr;
  logic             acc0, acc1, pop_ok;

  // Acceptance, drop detection and pointer/fill next state.
  always_comb begin
    free     = (AW+1)'(DEPTH) - fill_q;
    acc0     = push0 && (free != '0);
    acc1     = push1 && (free > (AW+1)'(acc0));
    drop     = (push0 && !acc0) || (push1 && !acc1);
    pop_ok   = pop && (fill_q != '0);
    // Second item lands behind the first only if the first was accepted.
    wr1_ptr  = acc0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + AW'(acc0) + AW'(acc1);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    fill_d   = fill_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (acc0) mem_q[wr_ptr_q] <= data0;
      if (acc1) mem_q[wr1_ptr]  <= data1;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign fill = fill_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip trace/halt monitor: logs WB-stage register writes and MEM-stage
// stores into a timestamped FIFO and requests a CPU halt on a cycle limit or
// an address watchpoint hit.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned NUM_WP      = 2,
  parameter int unsigned CYCLE_LIMIT = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic [NUM_WP*DATA_W-1:0] wp_addr,
  input  logic [NUM_WP-1:0]        wp_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [DATA_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic                     halt_req,
  output logic [1:0]               halt_cause,
  output logic [31:0]              cycle_count
);

  localparam int unsigned EW = 1 + 2 * DATA_W + TS_W;
  localparam logic [31:0] LimitM1 = (CYCLE_LIMIT == 0) ? 32'd0 : 32'(CYCLE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic        halt_req_q, halt_req_d;
  logic [1:0]  cause_q, cause_d;
  logic        overflow_q;

  logic          capture;
  logic          limit_hit, wp_match, wp_hit;
  logic          push_reg, push_mem, pop, drop;
  logic [EW-1:0] entry_reg, entry_mem, head;

  // Watchpoint compare across all enabled slots.
  always_comb begin
    wp_match = 1'b0;
    for (int i = 0; i < NUM_WP; i++) begin
      if (wp_en[i] && (mem_addr == wp_addr[i*DATA_W +: DATA_W])) wp_match = 1'b1;
    end
  end

  assign wp_hit    = mem_we && wp_match;
  assign limit_hit = (CYCLE_LIMIT != 0) && (cycle_q == LimitM1);

  // FSM next state, cycle counter and halt request.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    halt_req_d = halt_req_q;
    cause_d    = cause_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cycle_d    = '0;
        halt_req_d = 1'b0;
        cause_d    = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        // Events in the cycle enable drops are still logged.
        capture = 1'b1;
        if (!enable) begin
          state_d    = StIdle;
          cycle_d    = '0;
          halt_req_d = 1'b0;
          cause_d    = '0;
        end else begin
          cycle_d = sat_inc(cycle_q);
          if (limit_hit || wp_hit) begin
            state_d                 = StHalted;
            halt_req_d              = 1'b1;
            cause_d[HALT_LIMIT_BIT] = limit_hit;
            cause_d[HALT_WP_BIT]    = wp_hit;
          end
        end
      end
      StHalted: begin
        if (!enable) begin
          state_d    = StIdle;
          cycle_d    = '0;
          halt_req_d = 1'b0;
          cause_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, counter, halt and sticky overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      halt_req_q <= 1'b0;
      cause_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      halt_req_q <= halt_req_d;
      cause_q    <= cause_d;
      overflow_q <= overflow_q | drop;
    end
  end

  // Entry formatting: {kind, addr, data, timestamp}.
  always_comb begin
    push_reg  = capture && wb_valid && (wb_addr != 5'd0);
    push_mem  = capture && mem_we;
    entry_reg = {TRACE_REG, DATA_W'(wb_addr), wb_data, cycle_q[TS_W-1:0]};
    entry_mem = {TRACE_MEM, mem_addr, mem_wdata, cycle_q[TS_W-1:0]};
    pop       = out_valid && out_ready;
  end

  cpu_trace_buffer_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push_reg),
    .data0 (entry_reg),
    .push1 (push_mem),
    .data1 (entry_mem),
    .pop   (pop),
    .head  (head),
    .fill  (fill),
    .drop  (drop)
  );

  assign out_valid   = (fill != '0);
  assign out_kind    = head[EW-1];
  assign out_addr    = head[EW-2 -: DATA_W];
  assign out_data    = head[TS_W +: DATA_W];
  assign out_ts      = head[TS_W-1:0];
  assign overflow    = overflow_q;
  assign halt_req    = halt_req_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: capture, ordering, overflow, drain,
// cycle-limit and watchpoint halts, asynchronous reset.
module tb_cpu_trace_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned NUM_WP = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     wb_valid;
  logic [4:0]               wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [NUM_WP*DATA_W-1:0] wp_addr;
  logic [NUM_WP-1:0]        wp_en;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_kind;
  logic [DATA_W-1:0]        out_addr;
  logic [DATA_W-1:0]        out_data;
  logic [TS_W-1:0]          out_ts;
  logic [4:0]               fill;
  logic                     overflow;
  logic                     halt_req;
  logic [1:0]               halt_cause;
  logic [31:0]              cycle_count;

  int passed = 0;
  int total  = 0;

  cpu_trace_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wp_addr     (wp_addr),
    .wp_en       (wp_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_kind    (out_kind),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_ts      (out_ts),
    .fill        (fill),
    .overflow    (overflow),
    .halt_req    (halt_req),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_head(input string tag, input logic k, input logic [31:0] a,
                            input logic [31:0] d, input logic [15:0] t);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_kind"},  64'(out_kind),  64'(k));
    check({tag, "_addr"},  64'(out_addr),  64'(a));
    check({tag, "_data"},  64'(out_data),  64'(d));
    check({tag, "_ts"},    64'(out_ts),    64'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fill"},  64'(fill),        64'd0);
    check({tag, "_valid"}, 64'(out_valid),   64'd0);
    check({tag, "_kind"},  64'(out_kind),    64'd0);
    check({tag, "_addr"},  64'(out_addr),    64'd0);
    check({tag, "_data"},  64'(out_data),    64'd0);
    check({tag, "_ts"},    64'(out_ts),      64'd0);
    check({tag, "_ovf"},   64'(overflow),    64'd0);
    check({tag, "_halt"},  64'(halt_req),    64'd0);
    check({tag, "_cause"}, 64'(halt_cause),  64'd0);
    check({tag, "_cycle"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wp_addr   = '0;
    wp_en     = '0;
    out_ready = 1'b0;

    #3;
    check_all_zero("por");
    #4 reset = 1'b1;

    // IDLE -> RUN; first RUN cycle has cycle_count 0.
    enable = 1'b1;
    step();
    check("run_cycle0", 64'(cycle_count), 64'd0);
    repeat (4) step();
    check("run_cycle4", 64'(cycle_count), 64'd4);

    // Register write at RUN cycle 4.
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd187;
    step();
    check("reg_fill", 64'(fill), 64'd1);
    check_head("reg", 1'b0, 32'd3, 32'd187, 16'd4);

    // Write to x0 is not logged.
    wb_addr = 5'd0; wb_data = 32'd99;
    step();
    wb_valid = 1'b0;
    check("x0_fill", 64'(fill), 64'd1);

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop1_fill", 64'(fill), 64'd0);
    check("pop1_cycle", 64'(cycle_count), 64'd7);

    // Simultaneous register write and store at cycle 7.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
    mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'd121;
    step();
    wb_valid = 1'b0; mem_we = 1'b0;
    check("dual_fill", 64'(fill), 64'd2);
    check_head("dual0", 1'b0, 32'd5, 32'd7, 16'd7);
    out_ready = 1'b1;
    step();
    check("dual_fill1", 64'(fill), 64'd1);
    check_head("dual1", 1'b1, 32'h8, 32'd121, 16'd7);
    step();
    out_ready = 1'b0;
    check("dual_empty", 64'(out_valid), 64'd0);

    // 18 register writes into a 16-entry FIFO, cycles 10..27.
    for (int i = 1; i <= 18; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'(1000 + i);
      step();
    end
    wb_valid = 1'b0;
    check("ovf_fill", 64'(fill), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_cycle", 64'(cycle_count), 64'd28);

    // Head stays put while out_ready is low.
    step();
    check_head("hold", 1'b0, 32'd1, 32'd1001, 16'd10);

    // Drain in order (cycles 29..44).
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_head($sformatf("drain%0d", i), 1'b0, 32'(i), 32'(1000 + i), 16'(9 + i));
      step();
    end
    out_ready = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_fill", 64'(fill), 64'd0);
    check("drain_ovf", 64'(overflow), 64'd1);

    // Cycle limit: halt one cycle after cycle_count reaches 49.
    repeat (4) step();
    check("lim_cycle49", 64'(cycle_count), 64'd49);
    check("lim_pre_halt", 64'(halt_req), 64'd0);
    step();
    check("lim_halt", 64'(halt_req), 64'd1);
    check("lim_cause", 64'(halt_cause), 64'd1);
    check("lim_cycle50", 64'(cycle_count), 64'd50);

    // No capture and frozen counter while halted.
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;
    step();
    wb_valid = 1'b0;
    check("halted_fill", 64'(fill), 64'd0);
    check("halted_cycle", 64'(cycle_count), 64'd50);
    check("halted_req", 64'(halt_req), 64'd1);

    enable = 1'b0;
    step();
    check("idle_halt", 64'(halt_req), 64'd0);
    check("idle_cause", 64'(halt_cause), 64'd0);
    check("idle_cycle", 64'(cycle_count), 64'd0);

    // Watchpoint on slot 0 only; slot 1 disabled.
    wp_addr = {32'h100, 32'hC};
    wp_en   = 2'b01;
    enable  = 1'b1;
    step();
    mem_we = 1'b1; mem_addr = 32'hC; mem_wdata = 32'd153;
    step();
    mem_we = 1'b0;
    check("wp_halt", 64'(halt_req), 64'd1);
    check("wp_cause", 64'(halt_cause), 64'd2);
    check("wp_cycle", 64'(cycle_count), 64'd1);
    check("wp_fill", 64'(fill), 64'd1);
    check_head("wp", 1'b1, 32'hC, 32'd153, 16'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("wp_pop_fill", 64'(fill), 64'd0);

    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    repeat (10) step();
    // Store to the disabled slot's address does not halt.
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'd1;
    step();
    mem_we = 1'b0;
    check("wpdis_halt", 64'(halt_req), 64'd0);
    check("wpdis_fill", 64'(fill), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (37) step();
    check("both_cycle49", 64'(cycle_count), 64'd49);

    // Watchpoint hit on the limit cycle sets both cause bits.
    mem_we = 1'b1; mem_addr = 32'hC; mem_wdata = 32'd5;
    step();
    mem_we = 1'b0;
    check("both_cause", 64'(halt_cause), 64'd3);
    check("both_halt", 64'(halt_req), 64'd1);
    check("both_cycle", 64'(cycle_count), 64'd50);
    check_head("both", 1'b1, 32'hC, 32'd5, 16'd49);

    // Drain and return to IDLE, then fill 5 entries in RUN.
    out_ready = 1'b1;
    enable    = 1'b0;
    step();
    out_ready = 1'b0;
    enable    = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'(100 + i);
      step();
    end
    wb_valid = 1'b0;
    check("rst_pre_fill", 64'(fill), 64'd5);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #2 reset = 1'b0;
    #1;
    check_all_zero("arst");
    #1 reset = 1'b1;
    enable = 1'b0;
    step();
    check("post_rst_fill", 64'(fill), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
